// File: rtl/armleocpu_jtag_dtm.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_jtag_dtm
// Purpose  : RISC-V JTAG Debug Transport Module. Implements the DTMCS and
//            DMI data registers behind an external TAP controller and turns
//            DMI scans into request/response transactions on the DMI bus.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            ir_i                  - current TAP instruction
//            capture_i/shift_i/update_i - one-cycle DR state pulses
//            trst_ni               - one-cycle active-low test-logic reset
//            td_i / tdo_o          - serial data in / out
//            dmi_req_*             - DMI request channel (valid/ready)
//            dmi_resp_*            - DMI response channel (valid/ready)
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_jtag_dtm #(
  parameter int ABITS     = 7,
  parameter int IR_LENGTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IR_LENGTH-1:0] ir_i,
  input  logic                 capture_i,
  input  logic                 shift_i,
  input  logic                 update_i,
  input  logic                 trst_ni,
  input  logic                 td_i,
  output logic                 tdo_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [ABITS-1:0]     dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_op_i
);

  localparam int                   SRW       = ABITS + 34;
  localparam logic [IR_LENGTH-1:0] IR_DTMCS  = IR_LENGTH'(5'h10);
  localparam logic [IR_LENGTH-1:0] IR_DMI    = IR_LENGTH'(5'h11);
  localparam logic [5:0]           ABITS_FLD = 6'(ABITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RSP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SRW-1:0]   sr;
  logic [1:0]       sticky;
  logic [ABITS-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [1:0]       op_q;

  logic        sel_dtmcs;
  logic        sel_dmi;
  logic        busy;
  logic        hardreset;
  logic        abort;
  logic        dmi_accept;
  logic        resp_accept;
  logic [31:0] dtmcs_word;
  logic        req_valid;
  logic        resp_ready;

  assign sel_dtmcs = (ir_i == IR_DTMCS);
  assign sel_dmi   = (ir_i == IR_DMI);

  // Busy is taken from the state register, so a scan that coincides with
  // response acceptance still sees the transaction as outstanding.
  assign busy      = (state != ST_IDLE);

  assign hardreset = update_i && sel_dtmcs && sr[17];
  assign abort     = hardreset || !trst_ni;

  assign dmi_accept = update_i && sel_dmi && trst_ni && !busy &&
                      (sticky == 2'd0) &&
                      ((sr[1:0] == 2'd1) || (sr[1:0] == 2'd2));

  assign resp_accept = dmi_resp_valid_i && (state == ST_RSP);

  // {zeros, dmihardreset, dmireset, 0, idle=1, dmistat, abits, version=1}
  assign dtmcs_word = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, sticky, ABITS_FLD, 4'd1};

  assign tdo_o = (sel_dtmcs || sel_dmi) ? sr[0] : 1'b0;

  assign dmi_req_valid_o  = req_valid;
  assign dmi_resp_ready_o = resp_ready;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = wdata_q;
  assign dmi_req_op_o     = op_q;

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dmi_accept) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        req_valid = 1'b1;
        // A request accepted in the same cycle as an abort is already on the
        // bus, so its response still has to be drained.
        if (dmi_req_ready_i) begin
          state_nxt = abort ? ST_DRAIN : ST_RSP;
        end else if (abort) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RSP: begin
        resp_ready = 1'b1;
        if (dmi_resp_valid_i) begin
          state_nxt = ST_IDLE;
        end else if (abort) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        resp_ready = 1'b1;
        if (dmi_resp_valid_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift register, sticky error and transaction registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      sticky  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      op_q    <= 2'd0;
    end else begin
      if (resp_accept) begin
        rdata_q <= dmi_resp_data_i;
        if ((dmi_resp_op_i != 2'd0) && (sticky == 2'd0)) begin
          sticky <= 2'd2;
        end
      end

      // Later assignments override the response-error update above, so a
      // busy hit or an explicit clear in the same cycle takes precedence.
      if (!trst_ni) begin
        sticky <= 2'd0;
        sr     <= '0;
      end else if (capture_i) begin
        if (sel_dtmcs) begin
          sr <= {{(SRW-32){1'b0}}, dtmcs_word};
        end else if (sel_dmi) begin
          sr <= {addr_q, rdata_q, (busy ? 2'd3 : sticky)};
          if (busy && (sticky == 2'd0)) begin
            sticky <= 2'd3;
          end
        end
      end else if (shift_i) begin
        if (sel_dmi) begin
          sr <= {td_i, sr[SRW-1:1]};
        end else if (sel_dtmcs) begin
          sr[31:0] <= {td_i, sr[31:1]};
        end
      end else if (update_i) begin
        if (sel_dtmcs) begin
          if (sr[16] || sr[17]) begin
            sticky <= 2'd0;
          end
          if (sr[17]) begin
            sr <= '0;
          end
        end else if (sel_dmi) begin
          if (busy) begin
            if (sticky == 2'd0) begin
              sticky <= 2'd3;
            end
          end else if (dmi_accept) begin
            addr_q  <= sr[SRW-1:34];
            wdata_q <= sr[33:2];
            op_q    <= sr[1:0];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_jtag_dtm.sv
`default_nettype none
// ============================================================================
// Module   : tb_armleocpu_jtag_dtm
// Purpose  : Scoreboard bench for armleocpu_jtag_dtm. Stimulus tasks drive
//            DR scans and push expected scan-out words and DMI requests into
//            queues; independent monitors pop and compare them as the DUT
//            shifts data out or presents requests. A transaction-level model
//            tracks sticky error, last address and last read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_armleocpu_jtag_dtm;

  localparam int ABITS = 7;
  localparam int SRW   = ABITS + 34;

  logic             clk;
  logic             rst_n;
  logic [4:0]       ir_i;
  logic             capture_i;
  logic             shift_i;
  logic             update_i;
  logic             trst_ni;
  logic             td_i;
  logic             tdo_o;
  logic             dmi_req_valid_o;
  logic             dmi_req_ready_i;
  logic [ABITS-1:0] dmi_req_addr_o;
  logic [31:0]      dmi_req_data_o;
  logic [1:0]       dmi_req_op_o;
  logic             dmi_resp_valid_i;
  logic             dmi_resp_ready_o;
  logic [31:0]      dmi_resp_data_i;
  logic [1:0]       dmi_resp_op_i;

  armleocpu_jtag_dtm #(.ABITS(ABITS), .IR_LENGTH(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ir_i             (ir_i),
    .capture_i        (capture_i),
    .shift_i          (shift_i),
    .update_i         (update_i),
    .trst_ni          (trst_ni),
    .td_i             (td_i),
    .tdo_o            (tdo_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_addr_o   (dmi_req_addr_o),
    .dmi_req_data_o   (dmi_req_data_o),
    .dmi_req_op_o     (dmi_req_op_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_data_i  (dmi_resp_data_i),
    .dmi_resp_op_i    (dmi_resp_op_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  // Scoreboard queues
  logic [63:0]    exp_scan_q[$];
  int             exp_len_q[$];
  logic [SRW-1:0] exp_req_q[$];

  // Transaction-level reference model
  int          m_sticky = 0;
  logic [ABITS-1:0] m_addr = '0;
  logic [31:0] m_rdata  = '0;
  bit          m_busy   = 0;
  bit          m_drain  = 0;
  bit          m_req_seen = 0;

  // Environment controls
  bit          hold_resp     = 0;
  int          ready_mode    = 1;
  int          resp_op_force = 0;
  bit          use_force_data = 0;
  logic [31:0] force_data    = '0;

  logic [63:0] acc;
  int          nb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dtmcs_expect(input int st);
    return 32'((1 << 12) + (st << 10) + (ABITS << 4) + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_scan(input logic [63:0] v, input int n);
    tick();
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      shift_i = 1'b1;
      td_i    = v[i];
      tick();
    end
    shift_i  = 1'b0;
    td_i     = 1'b0;
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
  endtask

  task automatic dmi_scan(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op);
    logic [1:0]     os;
    logic [SRW-1:0] cap;
    logic [SRW-1:0] v;
    os  = m_busy ? 2'd3 : 2'(m_sticky);
    cap = {m_addr, m_rdata, os};
    if (m_busy && m_sticky == 0) m_sticky = 3;
    exp_scan_q.push_back(64'(cap));
    exp_len_q.push_back(SRW);
    ir_i = 5'h11;
    v = {a, d, op};
    do_scan(64'(v), SRW);
    if (m_busy) begin
      if (m_sticky == 0) m_sticky = 3;
    end else if (m_sticky == 0 && (op == 2'd1 || op == 2'd2)) begin
      exp_req_q.push_back(v);
      m_addr     = a;
      m_busy     = 1;
      m_req_seen = 0;
    end
  endtask

  task automatic dtmcs_scan(input logic [31:0] v);
    exp_scan_q.push_back(64'(dtmcs_expect(m_sticky)));
    exp_len_q.push_back(32);
    ir_i = 5'h10;
    do_scan(64'(v), 32);
    if (v[16] || v[17]) m_sticky = 0;
    if (v[17] && m_busy && m_req_seen) m_drain = 1;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: transaction still busy=1 expected busy=0 after timeout", name);
      m_busy = 0;
    end
  endtask

  task automatic wait_req_seen(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_req_seen) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: request handshake seen=0 expected seen=1 after timeout", name);
    end
  endtask

  // Request-ready driver: changes just after the edge so the negedge monitor
  // sees the value the DUT will sample.
  initial begin
    dmi_req_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dmi_req_ready_i = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Responder: answers an outstanding transaction after a random delay and
  // applies the response to the model once the DUT is committed to take it.
  initial begin
    logic [31:0] d;
    logic [1:0]  o;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i  = '0;
    dmi_resp_op_i    = '0;
    forever begin
      @(negedge clk);
      if (rst_n && dmi_resp_ready_o && !hold_resp && $urandom_range(0, 2) == 0) begin
        d = use_force_data ? force_data : $urandom;
        if (resp_op_force >= 0) o = 2'(resp_op_force);
        else o = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0;
        @(posedge clk);
        #1;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = d;
        dmi_resp_op_i    = o;
        @(negedge clk);
        if (m_drain) begin
          m_drain = 0;
        end else begin
          m_rdata = d;
          if (o != 2'd0 && m_sticky == 0) m_sticky = 2;
        end
        m_busy = 0;
        @(posedge clk);
        #1;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i  = $urandom;
        dmi_resp_op_i    = 2'($urandom_range(0, 3));
      end
    end
  end

  // Request monitor
  always @(negedge clk) begin
    if (dmi_req_valid_o && dmi_resp_ready_o) overlap++;
    if (rst_n && dmi_req_valid_o && dmi_req_ready_i) begin
      if (exp_req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got request addr 0x%0h op %0d expected none",
                 dmi_req_addr_o, dmi_req_op_o);
      end else begin
        check("req_payload", 64'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
              64'(exp_req_q.pop_front()));
      end
      m_req_seen = 1;
    end
  end

  // Scan-out monitor
  always @(negedge clk) begin
    logic [63:0] e;
    logic [63:0] mask;
    int          l;
    if (capture_i) begin
      acc = '0;
      nb  = 0;
    end else if (shift_i) begin
      if (nb < 64) acc[nb] = tdo_o;
      nb++;
    end else if (update_i && (ir_i == 5'h10 || ir_i == 5'h11)) begin
      if (exp_scan_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scan_unexpected: got 0x%0h expected no scan", acc);
      end else begin
        e = exp_scan_q.pop_front();
        l = exp_len_q.pop_front();
        mask = (l >= 64) ? '1 : ((64'd1 << l) - 64'd1);
        check("scan_len", 64'(nb), 64'(l));
        check("scan_out", acc & mask, e & mask);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [1:0]  op;
    logic        any_tdo;
    rst_n = 1'b0; trst_ni = 1'b1; ir_i = 5'h00;
    capture_i = 1'b0; shift_i = 1'b0; update_i = 1'b0; td_i = 1'b0;
    repeat (3) tick();
    check("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
    check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    check("rst_tdo", 64'(tdo_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // DTMCS after reset and an ignored op=0 DMI scan showing reset values
    dtmcs_scan(32'd0);
    dmi_scan('0, 32'd0, 2'd0);

    // Write then read with fixed read data
    resp_op_force = 0;
    dmi_scan(7'h10, 32'hDEADBEEF, 2'd2);
    wait_idle("write_done");
    use_force_data = 1; force_data = 32'h12345678;
    dmi_scan(7'h04, 32'h0, 2'd1);
    wait_idle("read_done");
    use_force_data = 0;
    dmi_scan('0, 32'd0, 2'd0);

    // Unselected IR: tdo stays low and registers are untouched
    ir_i = 5'h01;
    tick();
    capture_i = 1'b1; tick(); capture_i = 1'b0;
    any_tdo = 1'b0;
    for (int i = 0; i < 8; i++) begin
      shift_i = 1'b1; td_i = 1'b1;
      @(negedge clk);
      any_tdo = any_tdo | tdo_o;
      tick();
    end
    shift_i = 1'b0; update_i = 1'b1; tick(); update_i = 1'b0;
    check("unsel_tdo", 64'(any_tdo), 64'd0);
    dmi_scan('0, 32'd0, 2'd0);

    // Busy update sets sticky=3, blocks further updates until dmireset
    hold_resp = 1;
    dmi_scan(7'h20, $urandom, 2'd2);
    wait_req_seen("busy_req");
    dmi_scan(7'h21, $urandom, 2'd2);
    dtmcs_scan(32'd0);
    hold_resp = 0;
    wait_idle("busy_done");
    dmi_scan(7'h22, $urandom, 2'd2);
    dtmcs_scan(32'h0001_0000);
    dmi_scan(7'h23, $urandom, 2'd2);
    wait_idle("after_dmireset");

    // Failed response, trst clear, hardreset drain
    resp_op_force = 2;
    dmi_scan(7'h05, 32'd0, 2'd1);
    wait_idle("err_read");
    resp_op_force = 0;
    dtmcs_scan(32'd0);
    trst_ni = 1'b0; tick(); trst_ni = 1'b1;
    m_sticky = 0;
    dtmcs_scan(32'd0);
    hold_resp = 1;
    dmi_scan(7'h06, $urandom, 2'd2);
    wait_req_seen("drain_req");
    dtmcs_scan(32'h0002_0000);
    use_force_data = 1; force_data = 32'hCAFEF00D;
    hold_resp = 0;
    wait_idle("drain_done");
    use_force_data = 0;
    dmi_scan('0, 32'd0, 2'd0);

    // Randomized traffic
    resp_op_force = -1;
    for (int it = 0; it < 24; it++) begin
      op = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(1, 2)) : (($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0);
      dmi_scan(7'($urandom), $urandom, op);
      wait_idle("rand_txn");
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom;
        dtmcs_scan(r);
      end
    end
    resp_op_force = 0;

    // rst_n during REQ with ready held low
    dtmcs_scan(32'h0001_0000);
    ready_mode = 0;
    dmi_scan(7'h33, $urandom, 2'd2);
    repeat (3) tick();
    check("req_valid_held", 64'(dmi_req_valid_o), 64'd1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_valid", 64'(dmi_req_valid_o), 64'd0);
    check("rst_mid_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    rst_n = 1'b1;
    m_sticky = 0; m_addr = '0; m_rdata = '0; m_busy = 0; m_drain = 0;
    exp_req_q.delete();
    ready_mode = 1;
    dmi_scan('0, 32'd0, 2'd0);
    dtmcs_scan(32'd0);

    repeat (4) tick();
    check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    check("scan_queue_empty", 64'(exp_scan_q.size()), 64'd0);
    check("valid_ready_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/armleocpu_jtag_dtm.md
ARMLEOCPU_JTAG_DTM -- requirements
Module: armleocpu_jtag_dtm

Interface
REQ-001 SHALL have parameter ABITS, default 7: DMI address width, range 1..32.
REQ-002 SHALL have parameter IR_LENGTH, default 5: width of ir_i.
REQ-003 SHALL have port clk  input  1: clock; all state on posedge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port ir_i  input  IR_LENGTH: current instruction from the TAP.
REQ-006 SHALL have port capture_i  input  1: one-cycle capture-DR pulse.
REQ-007 SHALL have port shift_i  input  1: one-cycle shift-DR pulse.
REQ-008 SHALL have port update_i  input  1: one-cycle update-DR pulse.
REQ-009 SHALL have port trst_ni  input  1: one-cycle active-low test-logic reset pulse.
REQ-010 SHALL have port td_i  input  1: JTAG TDI.
REQ-011 SHALL have port tdo_o  output  1: DR serial output to the TAP.
REQ-012 SHALL have ports dmi_req_valid_o/dmi_req_ready_i  out/in  1/1: request handshake.
REQ-013 SHALL have ports dmi_req_addr_o/dmi_req_data_o/dmi_req_op_o  output  ABITS/32/2: request payload; op 1=read, 2=write.
REQ-014 SHALL have ports dmi_resp_valid_i/dmi_resp_ready_o  in/out  1/1: response handshake.
REQ-015 SHALL have ports dmi_resp_data_i/dmi_resp_op_i  input  32/2: response payload; op 0=ok, else failed.

Function
REQ-016 SHALL decode IR 0x10 as DTMCS, 0x11 as DMI; all other IR values leave registers untouched and drive tdo_o=0.
REQ-017 SHALL hold a shift register sr of ABITS+34 bits; tdo_o = sr[0] combinationally when DTMCS or DMI is selected.
REQ-018 SHALL on shift_i with DMI: sr <= {td_i, sr[ABITS+33:1]}; with DTMCS: sr[31:0] <= {td_i, sr[31:1]}, upper bits held.
REQ-019 SHALL on capture_i with DTMCS load sr[31:0] = {14'b0, 1'b0, 1'b0, 1'b0, idle=3'd1, dmistat=sticky[1:0], abits=ABITS[5:0], version=4'd1}, upper bits 0.
REQ-020 SHALL on capture_i with DMI load sr = {addr_q, rdata_q, opstat}; opstat = 3 if FSM not IDLE (and set sticky=3 if sticky==0), else sticky.
REQ-021 SHALL keep sticky error (2 bits, values 0/2/3), addr_q (ABITS), wdata/rdata_q (32), op_q (2).
REQ-022 SHALL on update_i with DMI, when FSM IDLE and sticky==0 and sr[1:0] in {1,2}: latch addr_q=sr[ABITS+33:34], wdata=sr[33:2], op_q=sr[1:0], go REQ.
REQ-023 SHALL on update_i with DMI and FSM not IDLE: set sticky=3 if sticky==0; issue nothing.
REQ-024 SHALL ignore DMI update with sr[1:0] in {0,3} or sticky!=0 (no request, no state change).
REQ-025 SHALL on update_i with DTMCS: sr[16] (dmireset) clears sticky; sr[17] (dmihardreset) clears sticky and aborts per REQ-029; both may be set.
REQ-026 SHALL implement FSM IDLE, REQ, RSP, DRAIN: REQ drives dmi_req_valid_o=1 with stable payload until dmi_req_ready_i, then RSP; RSP/DRAIN drive dmi_resp_ready_o=1 until dmi_resp_valid_i, then IDLE.
REQ-027 SHALL on response accepted in RSP: rdata_q <= dmi_resp_data_i; if dmi_resp_op_i!=0 and sticky==0, sticky <= 2.
REQ-028 SHALL discard responses accepted in DRAIN (rdata_q, sticky unchanged).
REQ-029 SHALL on abort (dmihardreset or trst_ni=0): REQ -> IDLE (valid drops next cycle), RSP -> DRAIN, IDLE/DRAIN unchanged; sticky and sr cleared.
REQ-030 SHALL evaluate busy from FSM state at cycle start: update/capture coinciding with response acceptance is treated as busy.
REQ-031 SHALL give the request handshake one-cycle latency: dmi_req_valid_o rises the cycle after the accepting update_i.
REQ-032 SHALL never assert dmi_req_valid_o and dmi_resp_ready_o together.

Reset
REQ-033 SHALL on rst_n=0 set FSM IDLE, sr/addr_q/wdata/rdata_q/op_q/sticky = 0, dmi_req_valid_o=0, dmi_resp_ready_o=0, tdo_o=0 (no IR selected) or sr[0]=0.
REQ-034 SHALL give rst_n priority over trst_ni and all pulses in the same cycle.

Verification
REQ-035 DTMCS capture with ABITS=7, sticky=0 -> 32 shifted-out bits = 0x00001071 LSB first.
REQ-036 DMI scan addr=0x10, data=0xDEADBEEF, op=2, ready next cycle, resp op=0 -> one request with that payload; next DMI capture shows opstat=0.
REQ-037 DMI read addr=0x04, resp data 0x12345678 op=0 -> next DMI capture sr[33:2]=0x12345678, opstat=0.
REQ-038 Second DMI update while in RSP -> no new request, sticky=3; DTMCS dmistat=3; later DMI update ignored until dmireset, then accepted.
REQ-039 Response op=2 -> sticky=2, DTMCS dmistat=2; dmihardreset while RSP -> DRAIN, next response discarded, rdata_q unchanged.
REQ-040 rst_n low mid-REQ with ready=0 -> next cycle dmi_req_valid_o=0, FSM IDLE, all registers 0.
